// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double dabble), one conversion in flight.
// Optional input digit check enabled by defining BCD2BIN_ERR_CHECK_EN; otherwise out_err is tied to 0.
module bcd2bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      out_bin,
  output logic                  out_err,
  output logic [1:0]            dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // in_ready is high only in IDLE, and out_valid/out_bin/out_err stay stable until accepted.

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SR_W-1:0]      sr_q, sr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [BIN_W-1:0]     out_bin_q, out_bin_d;
  logic [SR_W-1:0]      sr_shr;
  logic [SR_W-1:0]      sr_step;
  logic [3:0]           digit;

  // One iteration: halve the BCD field, then fix every digit that picked up an 8 from above.
  always_comb begin
    sr_shr  = sr_q >> 1;
    sr_step = sr_shr;
    digit   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = sr_shr[BIN_W + 4*i +: 4];
      if (digit >= 4'd8) begin
        sr_step[BIN_W + 4*i +: 4] = digit - 4'd3;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sr_d    = {in_bcd, {BIN_W{1'b0}}};
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_bin_d   = sr_step[BIN_W-1:0];
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
    end
  end

`ifdef BCD2BIN_ERR_CHECK_EN
  logic err_q, err_d;

  // Captured once at accept and held through SHIFT and DONE.
  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && in_valid) begin
      err_d = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        if (in_bcd[4*i +: 4] > 4'd9) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: latency, values, backpressure, mid-conversion reset, digit error flag.
module tb_bcd2bin_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_bin;
  logic        out_err;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

`ifdef BCD2BIN_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  bcd2bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_err   (out_err),
    .dbg_state (dbg_state)
  );

  // Clock and global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (observed running, expected done)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full conversion: accept, count edges to out_valid, optional backpressure, handshake.
  task automatic run_conv(input logic [15:0] bcd, input logic [13:0] exp_bin, input logic exp_err,
                          input int hold, input bit ready_early, input string tag);
    int   edges;
    logic rdy_bad;
    @(negedge clk);
    check({tag, " in_ready_before"}, in_ready, 1);
    in_bcd    = bcd;
    in_valid  = 1'b1;
    out_ready = ready_early;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bcd   = 16'hFFFF;
    edges    = 0;
    rdy_bad  = 1'b0;
    do begin
      @(posedge clk);
      edges++;
      #1;
      if (!out_valid && in_ready) rdy_bad = 1'b1;
    end while (!out_valid && edges < 40);
    // 14 edges after the accept edge, i.e. the 15th edge counting the accept edge itself
    check({tag, " latency_edges"}, edges, 14);
    check({tag, " in_ready_busy"}, rdy_bad, 0);
    check({tag, " in_ready_done"}, in_ready, 0);
    check({tag, " out_bin"}, out_bin, exp_bin);
    check({tag, " out_err"}, out_err, exp_err);
    if (!ready_early) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_bcd   = 16'h5555;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, " hold_valid"}, out_valid, 1);
        check({tag, " hold_bin"}, out_bin, exp_bin);
        check({tag, " hold_in_ready"}, in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " valid_cleared"}, out_valid, 0);
    check({tag, " in_ready_after"}, in_ready, 1);
    check({tag, " bin_held"}, out_bin, exp_bin);
  endtask

  initial begin
    int   guard_bad;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_bcd    = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_bin", out_bin, 0);
    check("reset out_err", out_err, 0);
    check("reset state", dbg_state, 0);

    run_conv(16'h0000, 14'd0,    1'b0, 0, 1'b0, "zero");
    run_conv(16'h1234, 14'd1234, 1'b0, 0, 1'b0, "v1234");
    run_conv(16'h9999, 14'd9999, 1'b0, 0, 1'b1, "v9999_early");
    run_conv(16'h0809, 14'd809,  1'b0, 5, 1'b0, "v0809_hold5");
    run_conv(16'h1000, 14'd1000, 1'b0, 0, 1'b1, "v1000_early");
    run_conv(16'h9999, 14'd9999, 1'b0, 0, 1'b1, "v9999_again");

    // Reset during the 7th SHIFT cycle of 0x0042
    @(negedge clk);
    in_bcd   = 16'h0042;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("abort in_shift", dbg_state, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    check("abort out_bin", out_bin, 0);
    check("abort out_err", out_err, 0);
    guard_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) guard_bad++;
    end
    check("abort never_presented", guard_bad, 0);
    run_conv(16'h0007, 14'd7, 1'b0, 0, 1'b0, "v0007");

    // Invalid tens digit still runs the algorithm: 1*1000 + 2*100 + 10*10 + 4 = 1304
    run_conv(16'h12A4, 14'd1304, ERR_EN, 0, 1'b0, "v12A4");
    run_conv(16'h0999, 14'd999,  1'b0,   0, 1'b0, "v0999");
    run_conv(16'hF000, 14'd15000, ERR_EN, 0, 1'b1, "vF000");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
